// File: rtl/add32_seq.sv
// rtl/add32_seq.sv - multi-cycle adder/subtractor sequencing one 4-bit CLA slice
//
// Purpose:
//   Adds (or subtracts) two WIDTH-bit operands one nibble per cycle, LSB first.
//   A single 4-bit carry-lookahead slice is reused across all nibbles. The carry
//   between nibbles is held in a register.
//   Operands are taken on one valid/ready handshake.
//   Sum and flags are returned on a second valid/ready handshake.
//
// Configuration:
//   ADD32_SEQ_SUB_EN - when defined, sub_i selects A - B.
//                      When undefined, sub_i is ignored and every operation is A + B.
//
// Parameters:
//   WIDTH        operand/result width; multiple of 4, at least 8 (N = WIDTH/4 slices)
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   in_valid_i   operand request
//   in_ready_o   idle, operands can be accepted
//   a_i, b_i     operands
//   sub_i        1 = A - B, 0 = A + B
//   out_valid_o  result available
//   out_ready_i  consumer takes the result
//   sum_o        result (modulo 2^WIDTH)
//   cout_o       carry out of MSB slice (subtract: 1 = no borrow)
//   ovf_o        signed overflow
//   zero_o       result is zero (registered with the result)

module add32_seq_cla4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       ci_i,
  output logic [3:0] s_o,
  output logic [4:0] co_o
);
  logic [3:0] g;
  logic [3:0] p;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // co_o[k] is the carry into bit k; co_o[4] leaves the slice.
  assign co_o[0] = ci_i;
  assign co_o[1] = g[0] | (p[0] & ci_i);
  assign co_o[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci_i);
  assign co_o[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & ci_i);
  assign co_o[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci_i);
  assign s_o = p ^ co_o[3:0];
endmodule

module add32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o
);
  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             eff_sub;
  logic [CW+1:0]    base;
  logic [3:0]       slice_s;
  logic [4:0]       slice_co;

`ifdef ADD32_SEQ_SUB_EN
  assign eff_sub = sub_i;
`else
  // Adder-only build: sub_i stays on the port so instantiations are unchanged.
  logic unused_sub;
  assign unused_sub = sub_i;
  assign eff_sub    = 1'b0;
`endif

  // Bit offset of the nibble currently being processed.
  assign base = {cnt_q, 2'b00};

  add32_seq_cla4 u_slice (
    .a_i  (a_q[base +: 4]),
    .b_i  (b_q[base +: 4]),
    .ci_i (carry_q),
    .s_o  (slice_s),
    .co_o (slice_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          a_d     = a_i;
`ifdef ADD32_SEQ_SUB_EN
          // Two's-complement subtract: A + ~B + 1, the +1 entering as carry-in.
          b_d     = eff_sub ? ~b_i : b_i;
`else
          b_d     = b_i;
`endif
          carry_d = eff_sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[base +: 4] = slice_s;
        carry_d          = slice_co[4];
        cnt_d            = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          cout_d  = slice_co[4];
          ovf_d   = slice_co[3] ^ slice_co[4];
          // sum_d already carries the final nibble, so this sees the full result.
          zero_d  = (sum_d == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        // Returning to IDLE (never straight to RUN) guarantees one idle cycle.
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
  assign ovf_o       = ovf_q;
  assign zero_o      = zero_q;
endmodule

// File: tb/tb_add32_seq.sv
// tb/tb_add32_seq.sv - self-checking bench for add32_seq (WIDTH 32 and 8)

module tb_add32_seq;
`ifdef ADD32_SEQ_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv32 = 1'b0, or32 = 1'b0, sub32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        ir32, ov32, c32, o32, z32;
  logic [31:0] s32;

  logic        iv8 = 1'b0, or8 = 1'b0, sub8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ir8, ov8, c8, o8, z8;
  logic [7:0]  s8;

  int n_checks = 0;
  int n_fail   = 0;

  add32_seq #(.WIDTH(32)) dut32 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv32), .in_ready_o(ir32),
    .a_i(a32), .b_i(b32), .sub_i(sub32), .out_valid_o(ov32), .out_ready_i(or32),
    .sum_o(s32), .cout_o(c32), .ovf_o(o32), .zero_o(z32)
  );

  add32_seq #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv8), .in_ready_o(ir8),
    .a_i(a8), .b_i(b8), .sub_i(sub8), .out_valid_o(ov8), .out_ready_i(or8),
    .sum_o(s8), .cout_o(c8), .ovf_o(o8), .zero_o(z8)
  );

  // Reference: result packed as {sum, cout, ovf, zero}.
  function automatic logic [34:0] ref32(input logic [31:0] a, input logic [31:0] b,
                                        input logic s);
    logic        eff;
    logic [31:0] bb;
    logic [32:0] full;
    logic        v;
    eff  = s & SUB_EN;
    bb   = eff ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + 33'(eff);
    v    = (a[31] == bb[31]) && (full[31] != a[31]);
    return {full[31:0], full[32], v, full[31:0] == 32'd0};
  endfunction

  function automatic logic [10:0] ref8(input logic [7:0] a, input logic [7:0] b,
                                       input logic s);
    logic       eff;
    logic [7:0] bb;
    logic [8:0] full;
    logic       v;
    eff  = s & SUB_EN;
    bb   = eff ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + 9'(eff);
    v    = (a[7] == bb[7]) && (full[7] != a[7]);
    return {full[7:0], full[8], v, full[7:0] == 8'd0};
  endfunction

  // Issue one 32-bit op, wait for out_valid (bounded), optionally complete the handshake.
  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input bit hs, output logic [34:0] res, output int lat);
    @(negedge clk);
    a32 = a; b32 = b; sub32 = s; iv32 = 1'b1;
    @(posedge clk);
    #1 iv32 = 1'b0;
    a32 = $urandom; b32 = $urandom;
    lat = 0;
    while (!ov32 && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    res = {s32, c32, o32, z32};
    if (hs) begin
      or32 = 1'b1;
      @(posedge clk);
      #1 or32 = 1'b0;
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     output logic [10:0] res, output int lat);
    @(negedge clk);
    a8 = a; b8 = b; sub8 = s; iv8 = 1'b1;
    @(posedge clk);
    #1 iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    res = {s8, c8, o8, z8};
    or8 = 1'b1;
    @(posedge clk);
    #1 or8 = 1'b0;
  endtask

  task automatic test_reset;
    logic [37:0] got;
    @(negedge clk);
    got = {ir32, ov32, s32, c32, o32, z32};
    n_checks++;
    if (got !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset32: got %h expected %h", got, {1'b1, 1'b0, 32'd0, 3'b000});
    end
    n_checks++;
    if ({ir8, ov8, s8, c8, o8, z8} !== {1'b1, 1'b0, 8'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL reset8: got %h expected %h", {ir8, ov8, s8, c8, o8, z8},
               {1'b1, 1'b0, 8'd0, 3'b000});
    end
  endtask

  task automatic test_wrap;
    logic [34:0] r;
    int lat;
    op32(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b1, r, lat);
    n_checks++;
    if (r !== {32'h0, 1'b1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL wrap: got %h expected %h", r, {32'h0, 3'b101});
    end
    n_checks++;
    if (lat !== 8) begin
      n_fail++;
      $display("FAIL wrap_latency: got %0d expected 8", lat);
    end
    n_checks++;
    if (ir32 !== 1'b1 || ov32 !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_idle: got ir=%b ov=%b expected ir=1 ov=0", ir32, ov32);
    end
  endtask

  task automatic test_overflow;
    logic [34:0] r;
    int lat;
    op32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, r, lat);
    n_checks++;
    if (r !== {32'h8000_0000, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL overflow: got %h expected %h", r, {32'h8000_0000, 3'b010});
    end
  endtask

  task automatic test_subtract;
    logic [34:0] r, e;
    int lat;
    e = SUB_EN ? {32'hFFFF_FFFE, 3'b000} : {32'h0000_000C, 3'b000};
    op32(32'd5, 32'd7, 1'b1, 1'b1, r, lat);
    n_checks++;
    if (r !== e) begin
      n_fail++;
      $display("FAIL subtract: got %h expected %h", r, e);
    end
    // Equal operands: zero result and, when subtracting, no borrow.
    e = SUB_EN ? {32'h0, 3'b101} : {32'hDEAD_BEEF + 32'hDEAD_BEEF, 3'b100};
    op32(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b1, r, lat);
    n_checks++;
    if (r !== e) begin
      n_fail++;
      $display("FAIL subtract_equal: got %h expected %h", r, e);
    end
  endtask

  task automatic test_random;
    logic [34:0] r, e;
    logic [31:0] a, b;
    logic s;
    int lat;
    for (int i = 0; i < 24; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      if (i == 0) begin a = 32'h8000_0000; b = 32'h8000_0000; end
      if (i == 1) begin a = 32'h0; b = 32'h0; s = 1'b0; end
      e = ref32(a, b, s);
      op32(a, b, s, 1'b1, r, lat);
      n_checks++;
      if (r !== e || lat !== 8) begin
        n_fail++;
        $display("FAIL random32[%0d]: a=%h b=%h sub=%b got %h lat %0d expected %h lat 8",
                 i, a, b, s, r, lat, e);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [34:0] r, held, e;
    logic [31:0] na, nb;
    int lat;
    op32(32'h0F0F_0F0F, 32'h1234_4321, 1'b0, 1'b0, held, lat);
    e = ref32(32'h0F0F_0F0F, 32'h1234_4321, 1'b0);
    n_checks++;
    if (held !== e) begin
      n_fail++;
      $display("FAIL bp_result: got %h expected %h", held, e);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (ov32 !== 1'b1 || ir32 !== 1'b0 || {s32, c32, o32, z32} !== e) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got ov=%b ir=%b res=%h expected ov=1 ir=0 res=%h",
                 i, ov32, ir32, {s32, c32, o32, z32}, e);
      end
      a32 = $urandom; b32 = $urandom; iv32 = (i % 2 == 0);
    end
    na = $urandom; nb = $urandom;
    @(negedge clk);
    a32 = na; b32 = nb; sub32 = 1'b0; iv32 = 1'b1; or32 = 1'b1;
    @(posedge clk);
    #1 or32 = 1'b0;
    n_checks++;
    if (ov32 !== 1'b0 || ir32 !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_handshake: got ov=%b ir=%b expected ov=0 ir=1", ov32, ir32);
    end
    @(posedge clk);
    #1 iv32 = 1'b0;
    n_checks++;
    if (ir32 !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_accept: got ir=%b expected 0", ir32);
    end
    lat = 0;
    while (!ov32 && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    r = {s32, c32, o32, z32};
    e = ref32(na, nb, 1'b0);
    n_checks++;
    if (r !== e || lat !== 8) begin
      n_fail++;
      $display("FAIL bp_next: got %h lat %0d expected %h lat 8", r, lat, e);
    end
    or32 = 1'b1;
    @(posedge clk);
    #1 or32 = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    logic [34:0] r;
    int lat;
    @(negedge clk);
    a32 = 32'hFFFF_FFFF; b32 = 32'h7777_7777; sub32 = 1'b0; iv32 = 1'b1;
    @(posedge clk);
    #1 iv32 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (ov32 !== 1'b0 || ir32 !== 1'b1 || s32 !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_run: got ov=%b ir=%b sum=%h expected ov=0 ir=1 sum=0",
               ov32, ir32, s32);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (ov32 !== 1'b0) break;
    end
    n_checks++;
    if (ov32 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_discard: got ov=%b expected 0", ov32);
    end
    op32(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, r, lat);
    n_checks++;
    if (r[34:3] !== 32'h2345_6789 || lat !== 8) begin
      n_fail++;
      $display("FAIL after_reset: got %h lat %0d expected 23456789 lat 8", r[34:3], lat);
    end
  endtask

  task automatic test_width8;
    logic [10:0] r, e;
    logic [7:0] a, b;
    logic s;
    int lat;
    op8(8'h80, 8'h80, 1'b0, r, lat);
    n_checks++;
    if (r !== {8'h00, 3'b111} || lat !== 2) begin
      n_fail++;
      $display("FAIL width8: got %h lat %0d expected %h lat 2", r, lat, {8'h00, 3'b111});
    end
    for (int i = 0; i < 12; i++) begin
      a = 8'($urandom); b = 8'($urandom); s = 1'($urandom_range(0, 1));
      e = ref8(a, b, s);
      op8(a, b, s, r, lat);
      n_checks++;
      if (r !== e || lat !== 2) begin
        n_fail++;
        $display("FAIL random8[%0d]: a=%h b=%h sub=%b got %h lat %0d expected %h lat 2",
                 i, a, b, s, r, lat, e);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_wrap();
    test_overflow();
    test_subtract();
    test_backpressure();
    test_reset_mid_run();
    test_width8();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
